// File: rtl/raster_arb_pkg.sv
// Shared types and limits for the rasterizer stream arbiters.
package raster_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int unsigned ARB_MAX_N = 16;

    // Requester index width; a single requester still gets a 1-bit index.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = unsigned'($clog2(n));
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after start, with wrap.
module rr_priority_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic            found,
    output logic [ID_W-1:0] winner
);

    localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(N);

    logic [ID_W:0] idx;

    // The extra index bit lets start+i exceed N before folding back; N need not be a power of 2.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = {1'b0, start} + (ID_W + 1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-locking N:1 valid/ready stream merger with a one-entry output register.
module stream_rr_arbiter
    import raster_arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned ID_W      = id_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       vld_in,
    input  logic [N-1:0]       last_in,
    input  logic [N*WIDTH-1:0] data_in,
    output logic [N-1:0]       rdy_in,
    output logic               vld_out,
    input  logic               rdy_out,
    output logic [WIDTH-1:0]   data_out,
    output logic               last_out,
    output logic [ID_W-1:0]    id_out,
    output logic               err_overlong
);

    localparam int unsigned     CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N - 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic [ID_W-1:0]  id_q;

    logic [ID_W-1:0]  start_idx;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [ID_W-1:0]  sel;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             slot_free;
    logic             xfer;

    assign start_idx = (last_grant_q == LAST_ID) ? '0 : last_grant_q + 1'b1;

    rr_priority_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req    (vld_in),
        .start  (start_idx),
        .found  (pick_found),
        .winner (pick_idx)
    );

    // Combinational from rdy_out so a draining slot can refill in the same cycle.
    assign slot_free = !vld_q || rdy_out;

    assign sel      = (state_q == ARB_LOCKED) ? grant_q : pick_idx;
    assign sel_last = last_in[sel];
    assign sel_data = data_in[int'(sel)*WIDTH +: WIDTH];

    always_comb begin
        rdy_in = '0;
        if (rst_n) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        rdy_in[sel] = slot_free;
                    end
                end
                ARB_LOCKED: begin
                    rdy_in[sel] = slot_free;
                end
                default: begin
                    rdy_in = '0;
                end
            endcase
        end
    end

    assign xfer = |(vld_in & rdy_in);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        if (xfer) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (sel_last) begin
                        last_grant_d = sel;
                    end else begin
                        state_d = ARB_LOCKED;
                        grant_d = sel;
                    end
                end
                ARB_LOCKED: begin
                    if (sel_last) begin
                        state_d      = ARB_IDLE;
                        last_grant_d = grant_q;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase

            // The count saturates; a non-final beat beyond the limit only raises the flag.
            if (sel_last) begin
                cnt_d = '0;
            end else if (cnt_q == MAX_CNT) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_ID;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // A new beat takes priority over draining, so vld stays high on back-to-back beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            id_q   <= '0;
        end else if (xfer) begin
            vld_q  <= 1'b1;
            data_q <= sel_data;
            last_q <= sel_last;
            id_q   <= sel;
        end else if (rdy_out) begin
            vld_q <= 1'b0;
        end
    end

    assign vld_out      = vld_q;
    assign data_out     = data_q;
    assign last_out     = last_q;
    assign id_out       = id_q;
    assign err_overlong = err_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: per-requester sources, per-requester expected queues.
module tb_stream_rr_arbiter;
    import raster_arb_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 64;
    localparam int unsigned MB  = 4;
    localparam int unsigned IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   vld_in;
    logic [N-1:0]   last_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   rdy_in;
    logic           vld_out;
    logic           rdy_out;
    logic [W-1:0]   data_out;
    logic           last_out;
    logic [IDW-1:0] id_out;
    logic           err_overlong;

    stream_rr_arbiter #(
        .N         (N),
        .WIDTH     (W),
        .MAX_BEATS (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_in       (vld_in),
        .last_in      (last_in),
        .data_in      (data_in),
        .rdy_in       (rdy_in),
        .vld_out      (vld_out),
        .rdy_out      (rdy_out),
        .data_out     (data_out),
        .last_out     (last_out),
        .id_out       (id_out),
        .err_overlong (err_overlong)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        int unsigned gap;
    } beat_t;

    beat_t       src_q[N][$];
    beat_t       exp_q[N][$];
    int          out_ids[$];
    int          out_cyc[$];
    bit          loaded[N];
    int unsigned gap_cnt[N];
    logic [N-1:0] fire_s;
    logic [3:0]  bp_pat;
    int          cyc, n_checks, n_fail, serial, bp_step;
    int          mon_last_id, mon_last_beat;
    bit          flush, bp_mode, lock_watch, ovl_watch, prev_stall;
    logic [63:0] prev_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_pkt(input int req, input int beats, input int gap_at, input int gap_len);
        beat_t b;
        for (int k = 1; k <= beats; k++) begin
            b.data = {8'(req), 48'(serial), 8'(k)};
            b.last = (k == beats);
            b.gap  = (k == gap_at) ? unsigned'(gap_len) : 0;
            serial++;
            src_q[req].push_back(b);
            exp_q[req].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < int'(N); i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            #2;
            done = all_empty() && !vld_out;
        end
        check_eq({tag, "_drain"}, 64'(done), 64'(1));
    endtask

    // Source driver: updates just after the edge, samples handshakes just before it.
    initial begin
        vld_in  = '0;
        last_in = '0;
        data_in = '0;
        rdy_out = 1'b1;
        fire_s  = '0;
        bp_step = 0;
        for (int i = 0; i < int'(N); i++) begin
            loaded[i]  = 1'b0;
            gap_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (flush) begin
                for (int i = 0; i < int'(N); i++) begin
                    src_q[i].delete();
                    exp_q[i].delete();
                    loaded[i] = 1'b0;
                end
                flush = 1'b0;
            end else begin
                for (int i = 0; i < int'(N); i++) begin
                    if (fire_s[i] && src_q[i].size() > 0) begin
                        void'(src_q[i].pop_front());
                        loaded[i] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!loaded[i] && src_q[i].size() > 0) begin
                    loaded[i]  = 1'b1;
                    gap_cnt[i] = src_q[i][0].gap;
                end
                if (loaded[i] && gap_cnt[i] == 0) begin
                    vld_in[i]         = 1'b1;
                    last_in[i]        = src_q[i][0].last;
                    data_in[i*W +: W] = src_q[i][0].data;
                end else begin
                    if (loaded[i]) gap_cnt[i]--;
                    vld_in[i]  = 1'b0;
                    last_in[i] = 1'b0;
                end
            end
            rdy_out = bp_mode ? bp_pat[bp_step % 4] : 1'b1;
            bp_step++;
            @(negedge clk);
            #4;
            fire_s = vld_in & rdy_in;
        end
    end

    // Output monitor and per-requester scoreboard.
    initial begin
        int    id;
        beat_t e;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                check_eq("rdy_onehot", 64'($countones(rdy_in) <= 1), 64'(1));
                if (prev_stall) begin
                    check_eq("bp_vld_hold", 64'(vld_out), 64'(1));
                    check_eq("bp_data_hold", data_out, prev_data);
                end
                if (vld_out && rdy_out) begin
                    id = int'(id_out);
                    out_ids.push_back(id);
                    out_cyc.push_back(cyc);
                    mon_last_id   = id;
                    mon_last_beat = int'(data_out[7:0]);
                    check_eq("sb_has_exp", 64'(exp_q[id].size() > 0), 64'(1));
                    if (exp_q[id].size() > 0) begin
                        e = exp_q[id].pop_front();
                        check_eq("sb_data", data_out, e.data);
                        check_eq("sb_last", 64'(last_out), 64'(e.last));
                    end
                    if (ovl_watch && id == 3) begin
                        check_eq("ovl_flag", 64'(err_overlong), 64'(data_out[7:0] >= 8'd5));
                    end
                end
                if (lock_watch && src_q[1].size() > 0) begin
                    check_eq("lock_rdy2", 64'(rdy_in[2]), 64'(0));
                end
                prev_stall = vld_out && !rdy_out;
                prev_data  = data_out;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  seen;
        n_checks    = 0;
        n_fail      = 0;
        serial      = 0;
        flush       = 1'b0;
        bp_mode     = 1'b0;
        lock_watch  = 1'b0;
        ovl_watch   = 1'b0;
        bp_pat      = 4'b1001;
        mon_last_id = -1;
        rst_n       = 1'b0;

        // Reset with every requester valid, then round-robin of 1-beat packets.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < int'(N); r++) push_pkt(r, 1, 0, 0);
        end
        repeat (3) begin
            @(negedge clk);
            #2;
            check_eq("rst_rdy_in", 64'(rdy_in), 64'(0));
            check_eq("rst_vld_out", 64'(vld_out), 64'(0));
        end
        check_eq("rst_data_out", data_out, 64'(0));
        check_eq("rst_last_out", 64'(last_out), 64'(0));
        check_eq("rst_id_out", 64'(id_out), 64'(0));
        check_eq("rst_err", 64'(err_overlong), 64'(0));
        rst_n = 1'b1;
        #1;
        check_eq("rst_first_rdy", 64'(rdy_in), 64'(4'b0001));
        wait_drain("rr", 100);
        check_eq("rr_count", 64'(out_ids.size()), 64'(12));
        for (int k = 0; k < 12 && k < out_ids.size(); k++) begin
            check_eq("rr_order", 64'(out_ids[k]), 64'(k % 4));
        end
        if (out_cyc.size() >= 12) begin
            check_eq("rr_throughput", 64'(out_cyc[11] - out_cyc[0]), 64'(11));
        end

        // Packet lock: requester 1 pauses mid-packet while requester 2 waits.
        base = out_ids.size();
        push_pkt(1, 5, 3, 2);
        push_pkt(2, 1, 1, 1);
        push_pkt(2, 1, 0, 0);
        lock_watch = 1'b1;
        wait_drain("lock", 100);
        lock_watch = 1'b0;
        check_eq("lock_count", 64'(out_ids.size() - base), 64'(7));
        for (int k = 0; k < 7 && base + k < out_ids.size(); k++) begin
            check_eq("lock_order", 64'(out_ids[base+k]), 64'((k < 5) ? 1 : 2));
        end

        // Backpressure with rdy_out cycling 1,0,0,1.
        base    = out_ids.size();
        bp_mode = 1'b1;
        push_pkt(0, 2, 0, 0);
        push_pkt(0, 2, 0, 0);
        push_pkt(3, 3, 0, 0);
        push_pkt(1, 1, 0, 0);
        wait_drain("bp", 200);
        bp_mode = 1'b0;
        check_eq("bp_count", 64'(out_ids.size() - base), 64'(8));

        // Overlong packet: 6 beats against a limit of 4.
        check_eq("ovl_pre", 64'(err_overlong), 64'(0));
        base      = out_ids.size();
        ovl_watch = 1'b1;
        push_pkt(3, 6, 0, 0);
        wait_drain("ovl", 100);
        ovl_watch = 1'b0;
        check_eq("ovl_count", 64'(out_ids.size() - base), 64'(6));
        repeat (3) @(negedge clk);
        #2;
        check_eq("ovl_sticky", 64'(err_overlong), 64'(1));

        // Reset during beat 2 of a 4-beat packet from requester 2.
        mon_last_id   = -1;
        mon_last_beat = -1;
        push_pkt(2, 4, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            #2;
            seen = (mon_last_id == 2) && (mon_last_beat == 2);
        end
        check_eq("rst2_seen_beat2", 64'(seen), 64'(1));
        rst_n = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        #2;
        check_eq("rst2_vld_out", 64'(vld_out), 64'(0));
        check_eq("rst2_state", 64'(dut.state_q), 64'(ARB_IDLE));
        check_eq("rst2_rdy_in", 64'(rdy_in), 64'(0));
        check_eq("rst2_err", 64'(err_overlong), 64'(0));
        push_pkt(2, 1, 0, 0);
        push_pkt(3, 1, 0, 0);
        push_pkt(0, 1, 0, 0);
        @(negedge clk);
        #2;
        base  = out_ids.size();
        rst_n = 1'b1;
        #1;
        check_eq("rst2_first_rdy", 64'(rdy_in), 64'(4'b0001));
        wait_drain("rst2", 100);
        check_eq("rst2_count", 64'(out_ids.size() - base), 64'(3));
        for (int k = 0; k < 3 && base + k < out_ids.size(); k++) begin
            check_eq("rst2_order", 64'(out_ids[base+k]), 64'((k == 0) ? 0 : k + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin, packet-locking arbiter that merges N valid/ready producer streams into one valid/ready consumer stream. It sits in front of a shared `axi_fifo`-style buffer and shares it between rasterizer stages, e.g. several triangle-setup lanes feeding one edge-walker queue. A grant is held for a whole packet, delimited by `last`, so beats of different packets never interleave. A one-entry registered output stage breaks the data path timing.

## Interface
- `N`, 4: number of requesters; legal range 1..16.
- `WIDTH`, 64: data beat width in bits.
- `MAX_BEATS`, 256: packet length limit; a longer packet sets the error flag.
- `ID_W`, `$clog2(N)` (1 when N=1): width of the requester index.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `vld_in`  in  N  per-requester valid.
- `last_in`  in  N  per-requester end-of-packet marker.
- `data_in`  in  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `rdy_in`  out  N  per-requester ready; at most one bit set (one-hot or zero).
- `vld_out`  out  1  output beat valid.
- `rdy_out`  in  1  consumer ready, e.g. the `rdy_in` of the downstream FIFO.
- `data_out`  out  WIDTH  output beat.
- `last_out`  out  1  end of packet.
- `id_out`  out  ID_W  index of the source requester.
- `err_overlong`  out  1  sticky: a packet exceeded MAX_BEATS beats.

## Operation
- `slot_free = !vld_out || rdy_out`. This is a combinational path from `rdy_out` to `rdy_in`.
- `last_grant` register, reset to N-1, so requester 0 wins first.
- **State ARB_IDLE:**
  - `winner` is the first i with `vld_in[i]`=1, scanning (last_grant+1) mod N upward with wrap.
  - `rdy_in[winner] = slot_free`; all other ready bits are 0.
  - On transfer with `last_in[winner]`=1: stay in ARB_IDLE and set `last_grant <= winner`.
  - On transfer with `last_in[winner]`=0: go to ARB_LOCKED with `grant <= winner`.
  - No transfer means no state change and no pointer update.
- **State ARB_LOCKED:**
  - `rdy_in[grant] = slot_free`; all other ready bits are 0, regardless of their valids.
  - If `vld_in[grant]` drops, the arbiter waits; it never releases mid-packet.
  - On transfer with `last_in[grant]`=1: go to ARB_IDLE and set `last_grant <= grant`.
- **Output register:** on any input transfer, load `data_out`, `last_out`, `id_out` and set `vld_out`=1. When `rdy_out` and no new beat arrives, clear `vld_out`. `data_out`/`id_out` hold their last value.
- **Beat counter:**
  - Width `$clog2(MAX_BEATS+1)`, saturating.
  - Counts transfers of the current packet and clears after a `last` beat.
  - A transfer when the count equals MAX_BEATS and `last`=0 sets `err_overlong`.
  - The packet still completes normally.
- **Width rules:** the pointer add wraps modulo N; N need not be a power of 2.

## Timing
- **Reset values:** `vld_out`=0, `data_out`=0, `last_out`=0, `id_out`=0, `err_overlong`=0, state ARB_IDLE, beat count 0, `last_grant`=N-1.
- While `rst_n`=0, `rdy_in`=0.
- **Latency:** an input beat accepted at edge k is presented on the output from edge k onward (1 register stage).
- **Throughput:** 1 beat/cycle while `rdy_out`=1, including back-to-back packets from different requesters (no idle bubble on switch).
- **Simultaneous events:** output drain and a new load in the same cycle → the new beat wins and `vld_out` stays 1.
- **Reset mid-packet:** the in-flight output beat and the lock are discarded; arbitration restarts from requester 0.

## Structure
- Package `raster_arb_pkg` holds:
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;`
  - localparam `ARB_MAX_N` = 16.
- Sub-module `rr_priority_pick`: combinational; takes N request bits and a start index, and returns `found` plus `winner` index. It is reusable by other schedulers.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with all `vld_in`=1 → `rdy_in`=0 and `vld_out`=0. After release, requester 0 is granted first and `id_out`=0.
- **Round-robin:** N=4, all four requesters stream 1-beat packets continuously, `rdy_out`=1 → `id_out` sequence 0,1,2,3,0,… at 1 beat/cycle.
- **Packet lock:**
  - Requester 1 sends a 5-beat packet.
  - Requester 2 is valid throughout.
  - Requester 1 drops `vld_in` for 2 cycles at beat 3.
  - Required response: all 5 beats come out with `id_out`=1 contiguously, and `rdy_in[2]` stays 0 until after beat 5.
- **Backpressure:** `rdy_out` toggles 1,0,0,1 → `data_out` stable while `vld_out`=1 and `rdy_out`=0, with no beat lost or duplicated (scoreboard per requester).
- **Overlong:** MAX_BEATS=4, requester 3 sends 6 beats with `last` on beat 6 → `err_overlong` rises after the transfer of beat 5 and stays 1; all 6 beats are delivered.
- **Reset mid-packet:** assert `rst_n`=0 at beat 2 of a 4-beat packet from requester 2 → next cycle `vld_out`=0 and the state is ARB_IDLE, and requester 0 wins next.
